// File: rtl/core_v2_pkg.sv
// Shared constants and encodings for the multi-cycle RV32I-subset core.
// Branch support is enabled by defining CORE_V2_BRANCH_EN (see core_v2_dec).
package core_v2_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_LUI
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_GE,
      BR_LTU,
      BR_GEU
   } br_cond_e;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/core_v2_dec.sv
// Combinational instruction decoder for core_v2.
// Branches decode as legal only when CORE_V2_BRANCH_EN is defined.
module core_v2_dec
   import core_v2_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic [31:0] instr_i,
   output logic [3:0]  alu_op_o,
   output logic        use_imm_o,
   output logic [31:0] imm32_o,
   output logic        rf_we_o,
   output logic        is_branch_o,
   output logic [2:0]  br_cond_o,
   output logic        illegal_o
);

   localparam logic [5:0] NREGS_W = 6'(NREGS);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       usesRs1;
   logic       usesRs2;
   logic       usesRd;
   logic       badOp;
   logic       badIdx;
   logic       rfWe;
   logic       isBranch;

   assign opcode = instr_i[OPC_LSB +: 7];
   assign funct3 = instr_i[F3_LSB +: 3];
   assign funct7 = instr_i[F7_LSB +: 7];
   assign rd     = instr_i[RD_LSB +: 5];
   assign rs1    = instr_i[RS1_LSB +: 5];
   assign rs2    = instr_i[RS2_LSB +: 5];

   always_comb begin
      alu_op_o  = ALU_ADD;
      use_imm_o = 1'b0;
      imm32_o   = sext12(instr_i[31:20]);
      rfWe      = 1'b0;
      isBranch  = 1'b0;
      br_cond_o = BR_EQ;
      badOp     = 1'b0;
      usesRs1   = 1'b0;
      usesRs2   = 1'b0;
      usesRd    = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            use_imm_o = 1'b1;
            rfWe      = 1'b1;
            usesRs1   = 1'b1;
            usesRd    = 1'b1;
            case (funct3)
               F3_ADD:  alu_op_o = ALU_ADD;
               F3_SLT:  alu_op_o = ALU_SLT;
               F3_SLTU: alu_op_o = ALU_SLTU;
               F3_XOR:  alu_op_o = ALU_XOR;
               F3_OR:   alu_op_o = ALU_OR;
               F3_AND:  alu_op_o = ALU_AND;
               F3_SLL: begin
                  alu_op_o = ALU_SLL;
                  badOp    = (funct7 != F7_BASE);
               end
               default: begin
                  if (funct7 == F7_BASE) alu_op_o = ALU_SRL;
                  else if (funct7 == F7_ALT) alu_op_o = ALU_SRA;
                  else badOp = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            rfWe    = 1'b1;
            usesRs1 = 1'b1;
            usesRs2 = 1'b1;
            usesRd  = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, F3_ADD}:  alu_op_o = ALU_ADD;
               {F7_ALT,  F3_ADD}:  alu_op_o = ALU_SUB;
               {F7_BASE, F3_SLL}:  alu_op_o = ALU_SLL;
               {F7_BASE, F3_SLT}:  alu_op_o = ALU_SLT;
               {F7_BASE, F3_SLTU}: alu_op_o = ALU_SLTU;
               {F7_BASE, F3_XOR}:  alu_op_o = ALU_XOR;
               {F7_BASE, F3_SR}:   alu_op_o = ALU_SRL;
               {F7_ALT,  F3_SR}:   alu_op_o = ALU_SRA;
               {F7_BASE, F3_OR}:   alu_op_o = ALU_OR;
               {F7_BASE, F3_AND}:  alu_op_o = ALU_AND;
               default:            badOp = 1'b1;
            endcase
         end
         OPC_LUI: begin
            use_imm_o = 1'b1;
            imm32_o   = {instr_i[31:12], 12'b0};
            alu_op_o  = ALU_LUI;
            rfWe      = 1'b1;
            usesRd    = 1'b1;
         end
`ifdef CORE_V2_BRANCH_EN
         OPC_BRANCH: begin
            // Word-addressed PC: a target not on a word boundary cannot be reached.
            imm32_o  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
            isBranch = 1'b1;
            usesRs1  = 1'b1;
            usesRs2  = 1'b1;
            badOp    = instr_i[8];
            case (funct3)
               F3_BEQ:  br_cond_o = BR_EQ;
               F3_BNE:  br_cond_o = BR_NE;
               F3_BLT:  br_cond_o = BR_LT;
               F3_BGE:  br_cond_o = BR_GE;
               F3_BLTU: br_cond_o = BR_LTU;
               F3_BGEU: br_cond_o = BR_GEU;
               default: badOp = 1'b1;
            endcase
         end
`endif
         default: badOp = 1'b1;
      endcase
   end

   assign badIdx = (usesRs1 && ({1'b0, rs1} >= NREGS_W)) ||
                   (usesRs2 && ({1'b0, rs2} >= NREGS_W)) ||
                   (usesRd  && ({1'b0, rd}  >= NREGS_W));

   assign illegal_o   = badOp || badIdx;
   assign rf_we_o     = rfWe && !illegal_o;
   assign is_branch_o = isBranch && !illegal_o;

endmodule

// File: rtl/core_v2.sv
// Multi-cycle RV32I-subset core: FETCH/EXEC/HALT FSM, register file, ALU and PC.
// Branch instructions are legal only when CORE_V2_BRANCH_EN is defined.
module core_v2
   import core_v2_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] PC_RESET = '0,
   parameter int              NREGS    = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic [PC_W-1:0] last_pc,
   output logic            retire,
   output logic [PC_W-1:0] retire_pc,
   output logic            illegal,
   output logic            halted
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       rf_q [32];

   logic [3:0]        decAluOp;
   logic              decUseImm;
   logic [31:0]       decImm;
   logic              decRfWe;
   logic              decIsBranch;
   logic [2:0]        decBrCond;
   logic              decIllegal;

   logic [4:0]        rdIdx, rs1Idx, rs2Idx;
   logic [31:0]       rs1Val, rs2Val, opB, aluRes;
   logic [4:0]        shamt;
   logic signed [31:0] immShift;
   logic              brTaken;
   logic [PC_W-1:0]   brTarget;
   logic [PC_W-1:0]   pcPlus1;
   logic              rfWe;

   core_v2_dec #(.NREGS(NREGS)) u_dec (
      .instr_i     (instr_q),
      .alu_op_o    (decAluOp),
      .use_imm_o   (decUseImm),
      .imm32_o     (decImm),
      .rf_we_o     (decRfWe),
      .is_branch_o (decIsBranch),
      .br_cond_o   (decBrCond),
      .illegal_o   (decIllegal)
   );

   assign rdIdx  = instr_q[RD_LSB +: 5];
   assign rs1Idx = instr_q[RS1_LSB +: 5];
   assign rs2Idx = instr_q[RS2_LSB +: 5];

   // x0 is never written, but force it to read zero regardless.
   assign rs1Val = (rs1Idx == 5'd0) ? 32'd0 : rf_q[rs1Idx];
   assign rs2Val = (rs2Idx == 5'd0) ? 32'd0 : rf_q[rs2Idx];
   assign opB    = decUseImm ? decImm : rs2Val;
   assign shamt  = opB[4:0];

   always_comb begin
      aluRes = '0;
      case (decAluOp)
         ALU_ADD:  aluRes = rs1Val + opB;
         ALU_SUB:  aluRes = rs1Val - opB;
         ALU_SLL:  aluRes = rs1Val << shamt;
         ALU_SLT:  aluRes = {31'd0, $signed(rs1Val) < $signed(opB)};
         ALU_SLTU: aluRes = {31'd0, rs1Val < opB};
         ALU_XOR:  aluRes = rs1Val ^ opB;
         ALU_SRL:  aluRes = rs1Val >> shamt;
         ALU_SRA:  aluRes = $signed(rs1Val) >>> shamt;
         ALU_OR:   aluRes = rs1Val | opB;
         ALU_AND:  aluRes = rs1Val & opB;
         ALU_LUI:  aluRes = opB;
         default:  aluRes = '0;
      endcase
   end

   // Byte offset converted to a word offset before adding to the word PC.
   assign immShift = $signed(decImm) >>> 2;
   assign brTarget = pc_q + PC_W'(immShift);
   assign pcPlus1  = pc_q + PC_W'(1);

   always_comb begin
      brTaken = 1'b0;
      case (decBrCond)
         BR_EQ:   brTaken = (rs1Val == rs2Val);
         BR_NE:   brTaken = (rs1Val != rs2Val);
         BR_LT:   brTaken = ($signed(rs1Val) <  $signed(rs2Val));
         BR_GE:   brTaken = ($signed(rs1Val) >= $signed(rs2Val));
         BR_LTU:  brTaken = (rs1Val <  rs2Val);
         BR_GEU:  brTaken = (rs1Val >= rs2Val);
         default: brTaken = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      imem_req = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
      rfWe     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            retire  = 1'b1;
            illegal = decIllegal;
            rfWe    = decRfWe && (rdIdx != 5'd0);
            pc_d    = (decIsBranch && brTaken) ? brTarget : pcPlus1;
            state_d = (pc_q == last_pc) ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   assign imem_addr = pc_q;
   assign retire_pc = pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= PC_RESET;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rfWe) begin
         rf_q[rdIdx] <= aluRes;
      end
   end

endmodule
